// File: rtl/wlan_interleaver_if.sv
// Serial coded-bit stream into the interleaver and symbol-framed bit stream out to the mapper.
interface wlan_interleaver_if;
  logic mode;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic out_bit;
  logic out_valid;
  logic out_ready;
  logic out_sof;
  logic out_eof;

  modport master (
    output mode, in_bit, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_sof, out_eof
  );

  modport slave (
    input  mode, in_bit, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/wlan_interleaver.sv
// 802.11a BPSK/QPSK transmit interleaver: permuted writes into a ping-pong bit buffer,
// in-order symbol readout. Each bank remembers its own symbol length (48 or 96).
module wlan_interleaver #(
  parameter int NCBPS_MAX = 96,
  parameter int K_W       = 7
) (
  input logic             clk,
  input logic             reset,
  wlan_interleaver_if.slave bus
);

  // Row/column permutation with 16 columns: p = (len/16)*(k mod 16) + k/16.
  function automatic logic [K_W-1:0] perm_idx(input logic [K_W-1:0] k, input logic len96);
    logic [K_W-1:0] row;
    logic [K_W-1:0] col;
    row = k & K_W'(15);
    col = k >> 3'd4;
    if (len96) begin
      perm_idx = row * K_W'(6) + col;
    end else begin
      perm_idx = row * K_W'(3) + col;
    end
  endfunction

  function automatic logic [K_W-1:0] last_idx(input logic len96);
    if (len96) begin
      last_idx = K_W'(95);
    end else begin
      last_idx = K_W'(47);
    end
  endfunction

  logic [NCBPS_MAX-1:0] bank_r [2];
  logic [1:0]           full_r;
  logic [1:0]           len96_r;
  logic                 wb_r;
  logic                 rb_r;
  logic [K_W-1:0]       k_r;
  logic [K_W-1:0]       j_r;

  logic                 wr_fire_s;
  logic                 wr_len96_s;
  logic                 wr_last_s;
  logic [K_W-1:0]       wr_pos_s;
  logic                 rd_fire_s;
  logic                 rd_last_s;

  // Handshake qualification; mode only matters on the first bit of a symbol.
  always_comb begin
    wr_fire_s = bus.in_valid & ~full_r[wb_r];
    if (k_r == '0) begin
      wr_len96_s = bus.mode;
    end else begin
      wr_len96_s = len96_r[wb_r];
    end
    wr_pos_s  = perm_idx(k_r, wr_len96_s);
    wr_last_s = (k_r == last_idx(wr_len96_s));
    rd_fire_s = full_r[rb_r] & bus.out_ready;
    rd_last_s = (j_r == last_idx(len96_r[rb_r]));
  end

  // Bank storage plus write/read pointers; both sides may complete a bank on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_r[0] <= '0;
      bank_r[1] <= '0;
      full_r    <= 2'b00;
      len96_r   <= 2'b00;
      wb_r      <= 1'b0;
      rb_r      <= 1'b0;
      k_r       <= '0;
      j_r       <= '0;
    end else begin
      if (wr_fire_s) begin
        bank_r[wb_r][wr_pos_s] <= bus.in_bit;
        if (k_r == '0) begin
          len96_r[wb_r] <= bus.mode;
        end
        if (wr_last_s) begin
          full_r[wb_r] <= 1'b1;
          k_r          <= '0;
          wb_r         <= ~wb_r;
        end else begin
          k_r <= k_r + K_W'(1);
        end
      end
      if (rd_fire_s) begin
        if (rd_last_s) begin
          full_r[rb_r] <= 1'b0;
          j_r          <= '0;
          rb_r         <= ~rb_r;
        end else begin
          j_r <= j_r + K_W'(1);
        end
      end
    end
  end

  // Output mux from registered state; everything reads as zero while no symbol is pending.
  always_comb begin
    bus.in_ready  = ~full_r[wb_r];
    bus.out_valid = full_r[rb_r];
    if (full_r[rb_r]) begin
      bus.out_bit = bank_r[rb_r][j_r];
      bus.out_sof = (j_r == '0);
      bus.out_eof = rd_last_s;
    end else begin
      bus.out_bit = 1'b0;
      bus.out_sof = 1'b0;
      bus.out_eof = 1'b0;
    end
  end

endmodule

// File: tb/tb_wlan_interleaver.sv
// Randomized bench for wlan_interleaver: forward permutation scoreboard on every output
// bit, plus an inverse-formula deinterleaver that must recover each transmitted symbol.
module tb_wlan_interleaver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wlan_interleaver_if ifc ();

  wlan_interleaver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct packed {
    logic b;
    logic sof;
    logic eof;
  } exp_t;

  exp_t        exp_q [$];
  logic [95:0] src_q [$];
  int          len_q [$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          rdy_mode = 0;
  logic [95:0] rx_buf;
  logic [95:0] last_rx;
  int          rx_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Downstream readiness: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ifc.out_ready = 1'b1;
        1:       ifc.out_ready = ($urandom_range(0, 3) != 0);
        default: ifc.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: sampled on the falling edge, ahead of the edge that transfers.
  always @(negedge clk) begin
    logic [95:0] rec;
    int          k;
    int          L;
    if (reset === 1'b1 && ifc.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        chk("out_bit_sof_eof", {ifc.out_sof, ifc.out_eof, ifc.out_bit},
            {exp_q[0].sof, exp_q[0].eof, exp_q[0].b});
        if (ifc.out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
          rx_buf[rx_cnt] = ifc.out_bit;
          rx_cnt++;
          if (ifc.out_eof) begin
            L   = len_q.pop_front();
            rec = '0;
            for (int i = 0; i < L; i++) begin
              k = 16 * i - (L - 1) * ((16 * i) / L);
              rec[k] = rx_buf[i];
            end
            chk("sym_len", rx_cnt, L);
            chk("loopback", rec, src_q.pop_front());
            last_rx = rx_buf;
            rx_buf  = '0;
            rx_cnt  = 0;
          end
        end
      end
    end
  end

  task automatic send_sym(input int L, input logic [95:0] bits, input bit gaps, output int stalls);
    logic [95:0] ov;
    exp_t        e;
    int          w;
    ov     = '0;
    stalls = 0;
    for (int k = 0; k < L; k++) ov[(L / 16) * (k % 16) + k / 16] = bits[k];
    for (int j = 0; j < L; j++) begin
      e.b   = ov[j];
      e.sof = (j == 0);
      e.eof = (j == L - 1);
      exp_q.push_back(e);
    end
    src_q.push_back(bits);
    len_q.push_back(L);
    for (int k = 0; k < L; k++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      ifc.in_valid = 1'b1;
      ifc.in_bit   = bits[k];
      if (k == 0 || !gaps) ifc.mode = (L == 96);
      else ifc.mode = $urandom_range(0, 1);
      w = 0;
      while (!ifc.in_ready && w < 5000) begin
        @(posedge clk);
        #1;
        w++;
        stalls++;
      end
      if (!ifc.in_ready) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 20000) begin
      @(posedge clk);
      c++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] rand_bits(input int L);
    logic [95:0] v;
    v = {$urandom, $urandom, $urandom};
    if (L == 48) v[95:48] = '0;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    int          base;
    int          L;
    logic [95:0] v;
    logic [95:0] exp_v;
    int          seq [4];
    seq = '{48, 96, 96, 48};

    ifc.mode = 1'b0; ifc.in_bit = 1'b0; ifc.in_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_outputs", {ifc.out_valid, ifc.out_sof, ifc.out_eof, ifc.out_bit}, 4'b0000);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: partial symbol discarded by reset
    for (int i = 0; i < 20; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_bit   = $urandom_range(0, 1);
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_mid_in_ready", ifc.in_ready, 1);
    chk("reset_mid_outputs", {ifc.out_valid, ifc.out_sof, ifc.out_eof, ifc.out_bit}, 4'b0000);
    base = n_out;
    send_sym(48, rand_bits(48), 1'b0, st);
    drain();
    chk("reset_mid_count", n_out - base, 48);

    // 2: single one at k=1 in 48 mode lands at j=3; out_valid right after last write
    v = '0; v[1] = 1'b1;
    send_sym(48, v, 1'b0, st);
    chk("latency_48", ifc.out_valid, 1);
    drain();
    exp_v = 96'h8;
    chk("perm48_k1", last_rx, exp_v);

    // 3: k=16 and k=95 in 96 mode land at j=1 and j=95
    v = '0; v[16] = 1'b1; v[95] = 1'b1;
    send_sym(96, v, 1'b0, st);
    chk("latency_96", ifc.out_valid, 1);
    drain();
    exp_v = '0; exp_v[1] = 1'b1; exp_v[95] = 1'b1;
    chk("perm96", last_rx, exp_v);

    // 4: back-to-back mixed symbols, input never stalls
    base = n_out;
    for (int s = 0; s < 4; s++) begin
      send_sym(seq[s], rand_bits(seq[s]), 1'b0, st);
      chk("b2b_no_stall", st, 0);
    end
    drain();
    chk("b2b_count", n_out - base, 288);

    // 5: backpressure with three symbols offered
    rdy_mode = 2;
    @(posedge clk);
    #1;
    base = n_out;
    send_sym(48, rand_bits(48), 1'b0, st);
    send_sym(96, rand_bits(96), 1'b0, st);
    chk("bp_in_ready_low", ifc.in_ready, 0);
    chk("bp_out_valid", ifc.out_valid, 1);
    fork
      send_sym(48, rand_bits(48), 1'b0, st);
    join_none
    repeat (10) @(posedge clk);
    #1;
    chk("bp_still_blocked", ifc.in_ready, 0);
    chk("bp_nothing_out", n_out - base, 0);
    rdy_mode = 0;
    wait fork;
    drain();
    chk("bp_count", n_out - base, 192);

    // 6: random loopback with mixed modes, input gaps and random backpressure
    rdy_mode = 1;
    for (int s = 0; s < 300; s++) begin
      L = ($urandom_range(0, 1) != 0) ? 96 : 48;
      send_sym(L, rand_bits(L), 1'b1, st);
    end
    drain();
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
